// File: rtl/fifo_mem_ctrl.sv
// Initiator-side FIFO controller for an external synchronous memory.
// Turns push/pop into registered mem commands and forwards read data back.
module fifo_mem_ctrl #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] address_write,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  read,
    output logic [ADDR_WIDTH-1:0] address_read,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  valid_out,
    input  logic                  err,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = ALMOST_FULL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = ALMOST_EMPTY[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic                  rst_d_reg;
    logic                  push_ok;
    logic                  pop_ok;
    logic [ADDR_WIDTH:0]   count_next;

    // Acceptance uses only the registered flags: no push/pop bypass in either direction.
    always_comb begin
        push_ok    = push & ~full;
        pop_ok     = pop & ~empty;
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET_L) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rst_d_reg     <= 1'b1;
            write         <= 1'b0;
            address_write <= '0;
            data          <= '0;
            read          <= 1'b0;
            address_read  <= '0;
            fifo_data     <= '0;
            fifo_valid    <= 1'b0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
            fifo_err      <= 1'b0;
        end else begin
            rst_d_reg <= 1'b0;
            write     <= push_ok;
            read      <= pop_ok;
            if (push_ok) begin
                address_write <= wr_ptr_reg;
                data          <= data_in;
                wr_ptr_reg    <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                address_read <= rd_ptr_reg;
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            fifo_err     <= fifo_err | (push & full) | (pop & empty) | err;
            // A read issued just before reset can still return one cycle after it; drop it.
            fifo_data    <= data_out;
            fifo_valid   <= valid_out & ~rst_d_reg;
        end
    end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Table-driven bench for fifo_mem_ctrl with a one-cycle-latency memory model
// and a timed scoreboard for the returned FIFO words.
module tb_fifo_mem_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_in = 1'b1;
    logic       push = 1'b0, pop = 1'b0, err = 1'b0;
    logic [5:0] data_in = '0;
    logic       write, read, fifo_valid, full, empty, almost_full, almost_empty, fifo_err;
    logic [2:0] address_write, address_read;
    logic [5:0] data, fifo_data;
    logic [3:0] count;
    logic [5:0] data_out = '0;
    logic       valid_out = 1'b0;

    fifo_mem_ctrl #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) dut (
        .clk(clk), .RESET_L(rst_in), .push(push), .data_in(data_in), .pop(pop),
        .write(write), .address_write(address_write), .data(data),
        .read(read), .address_read(address_read),
        .data_out(data_out), .valid_out(valid_out), .err(err),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .fifo_err(fifo_err)
    );

    // Memory: write on strobe, read data and valid one cycle after read.
    logic [5:0] mem_model [0:7];
    always @(posedge clk) begin
        if (write) mem_model[address_write] <= data;
        valid_out <= read;
        data_out  <= mem_model[address_read];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       wr;
        logic [2:0] aw;
        logic [5:0] d;
        logic       rd;
        logic [2:0] ar;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ferr;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       push;
        logic [5:0] din;
        logic       pop;
        logic       err;
        outs_t      exp;
        logic       ret_en;
        logic [5:0] ret_data;
    } vec_t;

    typedef struct {
        logic [5:0] data;
        int         due;
    } ret_t;

    vec_t       vecs[$];
    ret_t       ret_q[$];
    logic [5:0] stored[$];
    logic [2:0] e_wp, e_rp, e_aw, e_ar;
    logic [5:0] e_d;
    int         checks = 0;
    int         passes = 0;
    logic       mon_en = 1'b0;

    task automatic add_rst(input logic p, input logic q);
        vec_t v;
        e_wp = '0; e_rp = '0; e_aw = '0; e_ar = '0; e_d = '0;
        stored.delete();
        v.rst = 1'b1; v.push = p; v.din = 6'd63; v.pop = q; v.err = 1'b0;
        v.ret_en = 1'b0; v.ret_data = '0;
        v.exp = '0;
        v.exp.empty = 1'b1;
        v.exp.ae = 1'b1;
        vecs.push_back(v);
    endtask

    // x_wr/x_rd/x_cnt/x_ferr are the hand-chosen expectations for this cycle.
    task automatic add(input logic p, input logic [5:0] din, input logic q, input logic e,
                       input logic x_wr, input logic x_rd, input int x_cnt, input logic x_ferr);
        vec_t v;
        v.rst = 1'b0; v.push = p; v.din = din; v.pop = q; v.err = e;
        v.ret_en = 1'b0; v.ret_data = '0;
        if (x_rd) begin
            v.ret_en = 1'b1;
            v.ret_data = stored.pop_front();
            e_ar = e_rp;
            e_rp = e_rp + 1'b1;
        end
        if (x_wr) begin
            stored.push_back(din);
            e_aw = e_wp;
            e_d = din;
            e_wp = e_wp + 1'b1;
        end
        v.exp.wr = x_wr;  v.exp.aw = e_aw; v.exp.d = e_d;
        v.exp.rd = x_rd;  v.exp.ar = e_ar; v.exp.cnt = 4'(x_cnt);
        v.exp.full = (x_cnt == 8); v.exp.empty = (x_cnt == 0);
        v.exp.af = (x_cnt >= 6);   v.exp.ae = (x_cnt <= 2);
        v.exp.ferr = x_ferr;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n, input int cnt, input logic ferr);
        for (int k = 0; k < n; k++) add(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, cnt, ferr);
    endtask

    // Return-path scoreboard: each accepted pop must surface exactly at its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                checks++;
                if (fifo_valid !== 1'b1 || fifo_data !== ret_q[0].data)
                    $display("FAIL return cyc=%0d: got valid=%b data=%0d, expected valid=1 data=%0d",
                             cyc, fifo_valid, fifo_data, ret_q[0].data);
                else begin
                    passes++;
                    $display("cyc %0d return data=%0d", cyc, fifo_data);
                end
                void'(ret_q.pop_front());
            end else begin
                checks++;
                if (fifo_valid !== 1'b0)
                    $display("FAIL idle_return cyc=%0d: got valid=%b, expected valid=0", cyc, fifo_valid);
                else
                    passes++;
            end
        end
    end

    initial begin
        outs_t act;

        // Reset held two cycles, second one with push/pop asserted
        add_rst(1'b0, 1'b0);
        add_rst(1'b1, 1'b1);
        // Fill 1..8, then overflow
        for (int i = 1; i <= 8; i++) add(1'b1, 6'(i), 1'b0, 1'b0, 1'b1, 1'b0, i, 1'b0);
        add(1'b1, 6'd9, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1);
        // Refill, drain 8, then underflow
        add_rst(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) add(1'b1, 6'(i), 1'b0, 1'b0, 1'b1, 1'b0, i, 1'b0);
        for (int i = 0; i < 8; i++) add(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 7 - i, 1'b0);
        add(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle(3, 0, 1'b1);
        // Pointer wrap: push 5, pop 5, push 6, pop 6
        add_rst(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b1, 6'(10 + i), 1'b0, 1'b0, 1'b1, 1'b0, i + 1, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4 - i, 1'b0);
        for (int i = 0; i < 6; i++) add(1'b1, 6'(20 + i), 1'b0, 1'b0, 1'b1, 1'b0, i + 1, 1'b0);
        for (int i = 0; i < 6; i++) add(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5 - i, 1'b0);
        idle(3, 0, 1'b0);
        // Simultaneous push+pop at count 3
        add_rst(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b1, 6'(30 + i), 1'b0, 1'b0, 1'b1, 1'b0, i + 1, 1'b0);
        add(1'b1, 6'd40, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        idle(3, 3, 1'b0);
        // Simultaneous push+pop at count 0: pop rejected
        add_rst(1'b0, 1'b0);
        add(1'b1, 6'd41, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        // Memory error input alone sets the sticky flag
        add_rst(1'b0, 1'b0);
        add(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        idle(1, 0, 1'b1);
        // Reset with 4 words stored and a pop in flight
        add_rst(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b1, 6'(50 + i), 1'b0, 1'b0, 1'b1, 1'b0, i + 1, 1'b0);
        add(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        add_rst(1'b0, 1'b0);
        idle(3, 0, 1'b0);
        add(1'b1, 6'd60, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        add(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle(4, 0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_in  = vecs[i].rst;
            push    = vecs[i].push;
            data_in = vecs[i].din;
            pop     = vecs[i].pop;
            err     = vecs[i].err;
            if (vecs[i].ret_en) ret_q.push_back('{vecs[i].ret_data, cyc + 3});
            @(posedge clk);
            #1;
            if (vecs[i].rst) ret_q.delete();
            mon_en = 1'b1;
            act = '{write, address_write, data, read, address_read, count,
                    full, empty, almost_full, almost_empty, fifo_err};
            checks++;
            if (act !== vecs[i].exp)
                $display("FAIL row %0d: got wr=%b aw=%0d d=%0d rd=%b ar=%0d cnt=%0d f=%b e=%b af=%b ae=%b err=%b, expected %h (got %h)",
                         i, act.wr, act.aw, act.d, act.rd, act.ar, act.cnt, act.full, act.empty,
                         act.af, act.ae, act.ferr, vecs[i].exp, act);
            else begin
                passes++;
                $display("row %0d push=%b pop=%b rst=%b -> outs=%h", i, vecs[i].push, vecs[i].pop,
                         vecs[i].rst, act);
            end
        end

        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (ret_q.size() != 0)
            $display("FAIL pending_returns: got %0d outstanding, expected 0", ret_q.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
